// File: rtl/point_mult_ctrl_if.sv
// Shared types plus the request / gen_point / response bus of point_mult_ctrl.
package point_mult_ctrl_pkg;

    typedef struct packed {
        logic [255:0] p;
        logic [255:0] a;
        logic [255:0] b;
    } curve_parameters_t;

    typedef enum logic [1:0] {
        STATUS_OK         = 2'd0,
        STATUS_BAD_SCALAR = 2'd1,
        STATUS_TIMEOUT    = 2'd2,
        STATUS_R_ZERO     = 2'd3
    } status_e;

endpackage

interface point_mult_ctrl_if;
    import point_mult_ctrl_pkg::*;

    // request channel
    logic              req_valid;
    logic              req_ready;
    logic [255:0]      req_scalar;
    logic [255:0]      req_px;
    logic [255:0]      req_py;

    // gen_point side
    logic              gp_reset;
    logic [255:0]      gp_privKey;
    logic [255:0]      gp_in_x;
    logic [255:0]      gp_in_y;
    curve_parameters_t gp_params;
    logic              gp_done;
    logic [255:0]      gp_out_x;
    logic [255:0]      gp_out_y;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [255:0]      rsp_x;
    logic [255:0]      rsp_y;
    logic [255:0]      rsp_r;
    logic [1:0]        rsp_status;

    modport slave (
        input  req_valid, req_scalar, req_px, req_py,
        output req_ready,
        output gp_reset, gp_privKey, gp_in_x, gp_in_y, gp_params,
        input  gp_done, gp_out_x, gp_out_y,
        output rsp_valid, rsp_x, rsp_y, rsp_r, rsp_status,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_scalar, req_px, req_py,
        input  req_ready,
        input  gp_reset, gp_privKey, gp_in_x, gp_in_y, gp_params,
        output gp_done, gp_out_x, gp_out_y,
        input  rsp_valid, rsp_x, rsp_y, rsp_r, rsp_status,
        output rsp_ready
    );

endinterface

// File: rtl/point_mult_ctrl.sv
// Sequencer around gen_point: accepts a scalar and base point, range-checks the
// scalar against n, runs gen_point under a timeout, and returns (x, y, x mod n).
module point_mult_ctrl
    import point_mult_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned LAUNCH_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [255:0]      n_order,
    input  curve_parameters_t params,
    point_mult_ctrl_if.slave  bus
);

    // One counter serves both the LAUNCH hold and the RUN timeout.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > LAUNCH_CYCLES) ? TIMEOUT_CYCLES : LAUNCH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAUNCH_LOAD  = CNT_W'(LAUNCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LAUNCH, S_RUN, S_CAPTURE, S_REDUCE, S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             gp_reset_q, gp_reset_d;
    logic [255:0]     k_q, k_d;
    logic [255:0]     px_q, px_d;
    logic [255:0]     py_q, py_d;
    logic [255:0]     rsp_x_q, rsp_x_d;
    logic [255:0]     rsp_y_q, rsp_y_d;
    logic [255:0]     rsp_r_q, rsp_r_d;
    status_e          status_q, status_d;

    // Bit 256 is the borrow: set when x < n, so x is already reduced.
    logic [256:0]     x_minus_n;
    assign x_minus_n = {1'b0, rsp_x_q} - {1'b0, n_order};

    // Next-state and next-output logic for the whole operation sequence.
    always_comb begin
        // NOTE: every _d starts at its held value so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        px_d     = px_q;
        py_d     = py_q;
        rsp_x_d  = rsp_x_q;
        rsp_y_d  = rsp_y_q;
        rsp_r_d  = rsp_r_q;
        status_d = status_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    k_d     = bus.req_scalar;
                    px_d    = bus.req_px;
                    py_d    = bus.req_py;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((k_q == '0) || (k_q >= n_order)) begin
                    status_d = STATUS_BAD_SCALAR;
                    rsp_x_d  = '0;
                    rsp_y_d  = '0;
                    rsp_r_d  = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d   = LAUNCH_LOAD;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (bus.gp_done) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    status_d = STATUS_TIMEOUT;
                    rsp_x_d  = '0;
                    rsp_y_d  = '0;
                    rsp_r_d  = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                rsp_x_d = bus.gp_out_x;
                rsp_y_d = bus.gp_out_y;
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                // x < p < 2n, so one conditional subtraction fully reduces it.
                rsp_r_d  = x_minus_n[256] ? rsp_x_q : x_minus_n[255:0];
                status_d = (rsp_r_d == '0) ? STATUS_R_ZERO : STATUS_OK;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered copies of what the next state implies.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        gp_reset_d  = (state_d != S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            gp_reset_q  <= 1'b1;
            k_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_r_q     <= '0;
            status_q    <= STATUS_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            gp_reset_q  <= gp_reset_d;
            k_q         <= k_d;
            px_q        <= px_d;
            py_q        <= py_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_r_q     <= rsp_r_d;
            status_q    <= status_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.gp_reset   = gp_reset_q;
    assign bus.gp_privKey = k_q;
    assign bus.gp_in_x    = px_q;
    assign bus.gp_in_y    = py_q;
    assign bus.gp_params  = params;
    assign bus.rsp_x      = rsp_x_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_status = status_q;

endmodule

// File: tb/tb_point_mult_ctrl.sv
// Directed bench for point_mult_ctrl with a small gen_point stand-in.
module tb_point_mult_ctrl;
    import point_mult_ctrl_pkg::*;

    localparam int unsigned TIMEOUT   = 50;
    localparam int unsigned LAUNCH    = 2;
    localparam int unsigned MDL_DELAY = 3;
    // The stand-in registers gp_done on its 3rd free-running cycle; the controller sees it one cycle later.
    localparam int unsigned RUN_OK    = MDL_DELAY + 1;
    // Accept-to-rsp_valid: 2 for CHECK, LAUNCH hold, RUN cycles, then CAPTURE and REDUCE.
    localparam int unsigned LAT_OK    = 2 + LAUNCH + RUN_OK + 2;
    localparam int unsigned LAT_BAD   = 2;
    localparam int unsigned LAT_TO    = 2 + LAUNCH + TIMEOUT;

    localparam logic [255:0] N   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam logic [255:0] NP5 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364146;
    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

    logic              clk = 1'b0;
    logic              Reset;
    logic [255:0]      n_order;
    curve_parameters_t params;

    point_mult_ctrl_if bus();

    point_mult_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .LAUNCH_CYCLES (LAUNCH)
    ) dut (
        .clk    (clk),
        .Reset  (Reset),
        .n_order(n_order),
        .params (params),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // gen_point stand-in: counts while out of reset and raises done once, unless told to hang.
    logic [255:0] mdl_x = '0;
    logic [255:0] mdl_y = '0;
    logic         mdl_hang = 1'b0;
    int unsigned  mdl_cnt = 0;
    logic         mdl_done = 1'b0;
    always @(posedge clk) begin
        if (bus.gp_reset !== 1'b0) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else begin
            mdl_cnt  <= mdl_cnt + 1;
            mdl_done <= !mdl_hang && (mdl_cnt == MDL_DELAY - 1);
        end
    end
    assign bus.gp_done  = mdl_done;
    assign bus.gp_out_x = mdl_x;
    assign bus.gp_out_y = mdl_y;

    // Cycle counter for latency measurement.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts gp_reset-low cycles, captures gen_point inputs on release, flags req_ready while busy.
    int unsigned  gp_low_total = 0;
    int unsigned  ready_viol   = 0;
    logic         busy         = 1'b0;
    logic         gp_reset_prev = 1'b1;
    logic [255:0] cap_k = '0;
    logic [255:0] cap_x = '0;
    logic [255:0] cap_y = '0;
    always @(negedge clk) begin
        if (bus.gp_reset === 1'b0) begin
            gp_low_total++;
            if (gp_reset_prev === 1'b1) begin
                cap_k = bus.gp_privKey;
                cap_x = bus.gp_in_x;
                cap_y = bus.gp_in_y;
            end
        end
        if (busy && bus.req_ready !== 1'b0) ready_viol++;
        gp_reset_prev = bus.gp_reset;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int unsigned acc_cyc, low_snap, viol_snap;

    task automatic send_req(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y);
        int unsigned waited = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_before_accept", 256'(bus.req_ready), 256'd1);
        bus.req_valid  = 1'b1;
        bus.req_scalar = k;
        bus.req_px     = x;
        bus.req_py     = y;
        acc_cyc        = cyc;
        @(posedge clk);
        low_snap  = gp_low_total;
        viol_snap = ready_viol;
        busy      = 1'b1;
        #1;
        // Scramble the inputs: the operation must run from latched copies.
        bus.req_valid  = 1'b0;
        bus.req_scalar = {8{$urandom()}};
        bus.req_px     = {8{$urandom()}};
        bus.req_py     = {8{$urandom()}};
    endtask

    task automatic wait_rsp(input int unsigned max_cyc, output int unsigned lat);
        int unsigned waited = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_valid_seen", 256'(bus.rsp_valid), 256'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic release_rsp(input string name);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        busy = 1'b0;
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({name, ".rsp_valid_fall"}, 256'(bus.rsp_valid), 256'd0);
        check({name, ".req_ready_back"}, 256'(bus.req_ready), 256'd1);
    endtask

    task automatic run_op(input string name, input logic [255:0] k, input logic [1:0] exp_status,
                          input logic [255:0] exp_x, input logic [255:0] exp_y, input logic [255:0] exp_r,
                          input int unsigned exp_lat, input int unsigned exp_low);
        int unsigned lat;
        send_req(k, GX, GY);
        wait_rsp(200, lat);
        check({name, ".status"},   256'(bus.rsp_status), 256'(exp_status));
        check({name, ".rsp_x"},    bus.rsp_x, exp_x);
        check({name, ".rsp_y"},    bus.rsp_y, exp_y);
        check({name, ".rsp_r"},    bus.rsp_r, exp_r);
        check({name, ".latency"},  256'(lat), 256'(exp_lat));
        check({name, ".run_cyc"},  256'(gp_low_total - low_snap), 256'(exp_low));
        check({name, ".gp_reset"}, 256'(bus.gp_reset), 256'd1);
        check({name, ".ready_low"}, 256'(ready_viol - viol_snap), 256'd0);
        release_rsp(name);
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] snap_x, snap_y, snap_r;
        logic [1:0]   snap_s;
        int unsigned  bp_diff;
        int unsigned  lat;
        int unsigned  waited;

        Reset          = 1'b1;
        n_order        = N;
        params         = '{p: P, a: 256'd0, b: 256'd7};
        bus.req_valid  = 1'b0;
        bus.req_scalar = '0;
        bus.req_px     = '0;
        bus.req_py     = '0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("reset.req_ready",  256'(bus.req_ready), 256'd1);
        check("reset.rsp_valid",  256'(bus.rsp_valid), 256'd0);
        check("reset.gp_reset",   256'(bus.gp_reset), 256'd1);
        check("reset.rsp_x",      bus.rsp_x, 256'd0);
        check("reset.gp_privKey", bus.gp_privKey, 256'd0);
        check("gp_params.b",      bus.gp_params.b, 256'd7);
        check("gp_params.p",      bus.gp_params.p, P);

        // k = 1: result is G itself, r = Gx since Gx < n.
        mdl_x = GX; mdl_y = GY;
        run_op("k1", 256'd1, 2'd0, GX, GY, GX, LAT_OK, RUN_OK);
        check("k1.latched_k", cap_k, 256'd1);
        check("k1.latched_x", cap_x, GX);
        check("k1.latched_y", cap_y, GY);

        // k = 2: result 2G, also below n.
        mdl_x = G2X; mdl_y = G2Y;
        run_op("k2", 256'd2, 2'd0, G2X, G2Y, G2X, LAT_OK, RUN_OK);
        check("k2.latched_k", cap_k, 256'd2);

        // Out-of-range scalars never release gen_point and return zeros.
        run_op("k0", 256'd0, 2'd1, 256'd0, 256'd0, 256'd0, LAT_BAD, 0);
        run_op("kn", N,      2'd1, 256'd0, 256'd0, 256'd0, LAT_BAD, 0);
        run_op("kn_minus_1", N - 256'd1, 2'd0, G2X, G2Y, G2X, LAT_OK, RUN_OK);

        // gen_point never finishes: exactly TIMEOUT RUN cycles, then zeros.
        mdl_hang = 1'b1;
        run_op("timeout", 256'd5, 2'd2, 256'd0, 256'd0, 256'd0, LAT_TO, TIMEOUT);
        mdl_hang = 1'b0;

        // x = n + 5 reduces to 5.
        mdl_x = NP5; mdl_y = GY;
        run_op("x_n_plus_5", 256'd3, 2'd0, NP5, GY, 256'd5, LAT_OK, RUN_OK);

        // x = n reduces to 0, under 20 cycles of response backpressure with a competing request.
        mdl_x = N; mdl_y = G2Y;
        send_req(256'd7, GX, GY);
        wait_rsp(200, lat);
        snap_x = bus.rsp_x; snap_y = bus.rsp_y; snap_r = bus.rsp_r; snap_s = bus.rsp_status;
        bus.req_valid  = 1'b1;
        bus.req_scalar = 256'd9;
        bp_diff = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_x !== snap_x || bus.rsp_y !== snap_y || bus.rsp_r !== snap_r ||
                bus.rsp_status !== snap_s || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0)
                bp_diff++;
        end
        bus.req_valid = 1'b0;
        check("bp.stable",  256'(bp_diff), 256'd0);
        check("rz.status",  256'(bus.rsp_status), 256'd3);
        check("rz.rsp_r",   bus.rsp_r, 256'd0);
        check("rz.rsp_x",   bus.rsp_x, N);
        check("rz.latency", 256'(lat), 256'(LAT_OK));
        release_rsp("rz");

        // Reset in the middle of RUN.
        mdl_hang = 1'b1;
        send_req(256'd1, GX, GY);
        waited = 0;
        while ((gp_low_total - low_snap) < 5 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("midrun.reached_run", 256'(bus.gp_reset), 256'd0);
        Reset = 1'b1;
        @(posedge clk);
        busy = 1'b0;
        #1 Reset = 1'b0;
        @(negedge clk);
        check("midrun.req_ready",  256'(bus.req_ready), 256'd1);
        check("midrun.rsp_valid",  256'(bus.rsp_valid), 256'd0);
        check("midrun.gp_reset",   256'(bus.gp_reset), 256'd1);
        check("midrun.gp_privKey", bus.gp_privKey, 256'd0);
        check("midrun.status",     256'(bus.rsp_status), 256'd0);
        mdl_hang = 1'b0;

        // Controller works normally after the abort.
        mdl_x = G2X; mdl_y = G2Y;
        run_op("recover", 256'd2, 2'd0, G2X, G2Y, G2X, LAT_OK, RUN_OK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
